// File: rtl/risc_v_mike_mmio_arbiter_if.sv
// Request/response bundle for the two MMIO requesters plus the shared slave port.
// The slave modport is the arbiter's view; master is the fabric/peripheral side.
interface risc_v_mike_mmio_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0_val;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              rsp0_val;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              rsp0_err;

  logic              req1_val;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              rsp1_val;
  logic [DATA_W-1:0] rsp1_rdata;
  logic              rsp1_err;

  logic              mmio_val;
  logic              mmio_we;
  logic [ADDR_W-1:0] mmio_addr;
  logic [DATA_W-1:0] mmio_wr_data;
  logic [DATA_W-1:0] mmio_rd_data;

  modport slave (
    input  req0_val, req0_we, req0_addr, req0_wdata,
    input  req1_val, req1_we, req1_addr, req1_wdata,
    input  mmio_rd_data,
    output rsp0_val, rsp0_rdata, rsp0_err,
    output rsp1_val, rsp1_rdata, rsp1_err,
    output mmio_val, mmio_we, mmio_addr, mmio_wr_data
  );

  modport master (
    output req0_val, req0_we, req0_addr, req0_wdata,
    output req1_val, req1_we, req1_addr, req1_wdata,
    output mmio_rd_data,
    input  rsp0_val, rsp0_rdata, rsp0_err,
    input  rsp1_val, rsp1_rdata, rsp1_err,
    input  mmio_val, mmio_we, mmio_addr, mmio_wr_data
  );
endinterface

// File: rtl/risc_v_mike_mmio_arbiter.sv
// Two-requester MMIO arbiter: IDLE picks a winner and latches its request,
// ACCESS drives the slave for one cycle, RESP pulses the winner's response.
module risc_v_mike_mmio_arbiter #(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter logic [ADDR_W-1:0] MMIO_BASE = '0,
  parameter int              MMIO_SIZE = 8,
  parameter bit              RR_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  risc_v_mike_mmio_arbiter_if.slave bus,
  output logic busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // One extra bit so a window touching the top of the address space does not wrap.
  localparam logic [ADDR_W:0] LIMIT = {1'b0, MMIO_BASE} + (ADDR_W+1)'(MMIO_SIZE);

  state_t            state_q, state_d;
  logic              grant_q, last_grant_q, we_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  logic [1:0]        req_val;
  logic              win, sel_we, sel_err;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              acc, rsp;
  logic [1:0]        rsp_hit;

  assign req_val = {bus.req1_val, bus.req0_val};

  always_comb begin
    win = 1'b0;
    if (RR_EN) win = (&req_val) ? ~last_grant_q : req_val[1];
    else       win = ~req_val[0];
    sel_we    = win ? bus.req1_we    : bus.req0_we;
    sel_addr  = win ? bus.req1_addr  : bus.req0_addr;
    sel_wdata = win ? bus.req1_wdata : bus.req0_wdata;
    sel_err   = (sel_addr < MMIO_BASE) | ({1'b0, sel_addr} >= LIMIT) | (sel_addr[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_val) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (|req_val) begin
          grant_q <= win;
          we_q    <= sel_we;
          addr_q  <= sel_addr;
          wdata_q <= sel_wdata;
          err_q   <= sel_err;
          rdata_q <= '0;
        end
        // Writes and rejected accesses return zero read data.
        ACCESS:  rdata_q <= (!err_q && !we_q) ? bus.mmio_rd_data : '0;
        RESP:    last_grant_q <= grant_q;
        default: ;
      endcase
    end
  end

  assign acc     = (state_q == ACCESS) && !err_q;
  assign rsp     = (state_q == RESP);
  assign rsp_hit = {rsp & grant_q, rsp & ~grant_q};

  assign bus.mmio_val     = acc;
  assign bus.mmio_we      = acc & we_q;
  assign bus.mmio_addr    = acc ? (addr_q - MMIO_BASE) : '0;
  assign bus.mmio_wr_data = acc ? wdata_q : '0;

  assign bus.rsp0_val   = rsp_hit[0];
  assign bus.rsp0_rdata = rsp_hit[0] ? rdata_q : '0;
  assign bus.rsp0_err   = rsp_hit[0] & err_q;
  assign bus.rsp1_val   = rsp_hit[1];
  assign bus.rsp1_rdata = rsp_hit[1] ? rdata_q : '0;
  assign bus.rsp1_err   = rsp_hit[1] & err_q;

  assign busy = (state_q != IDLE);
endmodule

// File: doc/risc_v_mike_mmio_arbiter.md
Name: risc_v_mike_mmio_arbiter

Overview:
- Shares one MMIO slave port, such as the GPIO block, between two requesters: requester 0 is the core data port and requester 1 is the debug/DMA port.
- Arbitrates between them, sequences each access through a 3-state FSM, range-checks the address and registers the read data back to the winner.
- Sits between the core/debug fabric and the MMIO peripheral decode.
- Exactly one transaction is outstanding at any time.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MMIO_BASE, 32'h0000_0000, byte base address of the slave window.
- MMIO_SIZE, 8, window size in bytes; must be a multiple of 4.
- RR_EN, 1, arbitration mode: 1 = round-robin, 0 = fixed priority with requester 0 highest.

Ports:
- clk  in  1  clock; the only clock domain.
- rst  in  1  reset; synchronous, active-high.
- req0_val  in  1  requester 0 request; held until rsp0_val.
- req0_we  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  byte address.
- req0_wdata  in  DATA_W  write data.
- rsp0_val  out  1  one-cycle response pulse.
- rsp0_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp0_err  out  1  address error; valid with rsp0_val.
- req1_val, req1_we, req1_addr, req1_wdata, rsp1_val, rsp1_rdata, rsp1_err: same as requester 0, for requester 1.
- mmio_val  out  1  slave access strobe.
- mmio_we  out  1  slave write enable.
- mmio_addr  out  ADDR_W  window offset (addr - MMIO_BASE).
- mmio_wr_data  out  DATA_W  slave write data.
- mmio_rd_data  in  DATA_W  slave read data; combinational from mmio_addr.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE; last_grant = 1, so requester 0 wins the first contention.
  - All outputs 0; latched addr/we/wdata/rdata/err registers 0.
- FSM IDLE:
  - If neither reqN_val is high: stay in IDLE.
  - Otherwise select the winner.
    - RR_EN=1: if both request, grant the one that is not last_grant; otherwise grant the sole requester.
    - RR_EN=0: requester 0 always wins.
  - Latch the winner's id, we, addr and wdata.
  - Compute err = (addr < MMIO_BASE) | (addr >= MMIO_BASE+MMIO_SIZE) | (addr[1:0] != 0).
  - Go to ACCESS.
- FSM ACCESS, exactly one cycle:
  - If err=0: mmio_val=1, mmio_we=latched we, mmio_addr=latched addr - MMIO_BASE (ADDR_W wrap, no overflow flag), mmio_wr_data=latched wdata.
  - If err=0 and we=0: capture mmio_rd_data into the rdata register at the end of this cycle.
  - If err=1: mmio_val stays 0, rdata=0, the slave sees nothing.
  - Go to RESP.
- FSM RESP, exactly one cycle:
  - Drive the winner's rspN_val=1 with rspN_rdata (0 if write or err) and rspN_err.
  - The loser's rsp outputs stay 0.
  - last_grant <= winner id. Go to IDLE.
- Outside RESP: rspN_rdata and rspN_err are 0.
- mmio_we, mmio_addr, mmio_wr_data are 0 whenever mmio_val=0.
- Latency and throughput:
  - req sampled in IDLE at cycle N → mmio_val at N+1 → rsp at N+2.
  - The next arbitration is at N+3, so peak throughput is one access per 3 cycles.
- Request changes during ACCESS/RESP are ignored because the latched copy is used.
- A requester must keep req high until its rsp. If it drops early, the latched transaction still completes and the rsp still pulses.
- The loser's req stays pending and, with RR_EN=1, wins the next IDLE.
- rst asserted in any state: next cycle is IDLE with all outputs 0. An in-flight transaction is abandoned with no rsp; a write issued in ACCESS before the rst edge stands.
- busy = (state != IDLE).

Test Plan:
- Single read: MMIO_BASE=0; GPIO in-register value 0xA5 via slave model; req0 read addr 0x4 at cycle N → mmio_val=1, mmio_addr=0x4 at N+1; rsp0_val=1, rsp0_rdata=0xA5, rsp0_err=0 at N+2; busy high N+1..N+2.
- Write: req1 write addr 0x0, wdata 0x3C → mmio_val=1, mmio_we=1, mmio_wr_data=0x3C one cycle later; rsp1_val with rdata=0, err=0.
- Contention, RR_EN=1: req0 and req1 both held from reset → grants 0,1,0,1 with rsp pulses every 3 cycles. RR_EN=0: req0 is granted every time while req0 stays asserted.
- Errors: addr 0x8 (out of window) and addr 0x2 (misaligned) → mmio_val never asserts; rsp_err=1, rdata=0, latency unchanged.
- Offset mapping: MMIO_BASE=0x4000_0000, access 0x4000_0004 → mmio_addr=0x4; access 0x3FFF_FFFC → err=1.
- Reset mid-transaction: assert rst during ACCESS of a read → next cycle IDLE, busy=0, no rsp; a fresh req0 after rst drop is served with normal latency and requester 0 priority.
